// File: rtl/mux_16to1.sv
//------------------------------------------------------------------------------
// mux_16to1
//
// Single-bit 16-to-1 selector. Picks one bit of a 16-bit vector by a 4-bit
// index. The result is available combinationally on `out`. A registered copy
// is available on `out_q` for downstream synchronous logic.
//
// The selection is built as a balanced tree of 15 two-input muxes in four
// levels. Level n is steered by sel[n], so the tree result equals in[sel]
// bit-exactly for every select code. There are no invalid codes.
//
// Ports:
//   clk    in   1   system clock, rising edge active
//   rst    in   1   synchronous active-high reset (clears out_q only)
//   in     in  16   data vector; bit i is candidate i
//   sel    in   4   unsigned index of the selected bit, 0..15
//   out    out  1   combinational selection, in[sel]
//   out_q  out  1   out registered on the rising edge of clk
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module mux_16to1 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in,
  input  logic [3:0]  sel,
  output logic        out,
  output logic        out_q
);

  // Tree nodes, one vector per level. Level 0 holds 8 nodes, level 3 is root.
  logic [7:0] w_lvl0;
  logic [3:0] w_lvl1;
  logic [1:0] w_lvl2;
  logic       w_lvl3;

  logic       r_out_q;

  // The ternary operator keeps simulation semantics useful: a selected X/Z
  // data bit propagates, and an X select resolves only when both legs agree.
  for (genvar k = 0; k < 8; k++) begin : g_lvl0
    assign w_lvl0[k] = sel[0] ? in[2*k+1] : in[2*k];
  end

  for (genvar k = 0; k < 4; k++) begin : g_lvl1
    assign w_lvl1[k] = sel[1] ? w_lvl0[2*k+1] : w_lvl0[2*k];
  end

  for (genvar k = 0; k < 2; k++) begin : g_lvl2
    assign w_lvl2[k] = sel[2] ? w_lvl1[2*k+1] : w_lvl1[2*k];
  end

  assign w_lvl3 = sel[3] ? w_lvl2[1] : w_lvl2[0];

  // The combinational output is independent of clk and rst.
  assign out = w_lvl3;

  // NOTE: state updates use non-blocking assignments so every register
  // samples values from before the edge, regardless of process ordering.
  // The reset is synchronous: it is checked only inside the clocked process.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_q <= 1'b0;
    end else begin
      r_out_q <= w_lvl3;
    end
  end

  assign out_q = r_out_q;

endmodule

// File: tb/tb_mux_16to1.sv
//------------------------------------------------------------------------------
// tb_mux_16to1
//
// Directed self-checking bench for mux_16to1. Inputs change away from the
// rising edge. The combinational output is sampled 1 ns after each input
// change. The registered output is sampled 1 ns after each rising edge.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mux_16to1;

  logic        clk;
  logic        rst;
  logic [15:0] in;
  logic [3:0]  sel;
  logic        out;
  logic        out_q;

  int n_checks = 0;
  int n_errors = 0;

  mux_16to1 dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in),
    .sel   (sel),
    .out   (out),
    .out_q (out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic observed, input logic expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  initial begin
    logic [15:0] in_v;
    logic [3:0]  sel_v;
    logic        rst_v;
    logic        exp_out;
    logic        exp_q;
    logic [15:0] walk;

    rst = 1'b1;
    in  = 16'h0000;
    sel = 4'd0;

    // Reset state of the register.
    @(posedge clk); #1;
    check("reset_q", out_q, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Counting data with a fixed select: out follows in[0].
    begin
      logic [7:0] exp_cnt;
      exp_cnt = 8'b1010_1010;  // bit v = expected out for in = v
      for (int v = 0; v < 8; v++) begin
        in  = 16'(v);
        sel = 4'd0;
        #1;
        check($sformatf("count_in%0d", v), out, exp_cnt[v]);
        #9;
      end
    end

    // Select sweep with wrap: in = 0x0007, sel 1..15 then 0.
    in = 16'h0007;
    sel = 4'd0;
    for (int s = 1; s <= 16; s++) begin
      sel = sel + 4'd1;  // last increment wraps 15 -> 0
      #1;
      exp_out = (s == 1 || s == 2 || s == 16) ? 1'b1 : 1'b0;
      check($sformatf("sweep_step%0d", s), out, exp_out);
      #9;
    end

    // Walking one and walking zero across every select value.
    for (int i = 0; i < 16; i++) begin
      walk = 16'h0001 << i;
      for (int s = 0; s < 16; s++) begin
        in  = walk;
        sel = 4'(s);
        #1;
        check($sformatf("walk1_i%0d_s%0d", i, s), out, (s == i));
        in = ~walk;
        #1;
        check($sformatf("walk0_i%0d_s%0d", i, s), out, (s != i));
      end
    end

    // An unknown on the selected data bit reaches the output.
    in  = 16'h0000;
    in[3] = 1'bx;
    sel = 4'd3;
    #1;
    check("x_selected", out, 1'bx);
    sel = 4'd4;
    #1;
    check("x_unselected", out, 1'b0);

    // Register and reset: rst held two edges while out = 1.
    @(negedge clk);
    rst = 1'b1;
    in  = 16'hFFFF;
    sel = 4'd5;
    @(posedge clk); #1;
    check("rst_edge1_q", out_q, 1'b0);
    @(posedge clk); #1;
    check("rst_edge2_q", out_q, 1'b0);
    check("rst_out_comb", out, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_release_q", out_q, 1'b1);
    @(negedge clk);
    sel = 4'd6;
    in  = 16'hFFBF;
    #1;
    check("sel6_out", out, 1'b0);
    check("sel6_q_before_edge", out_q, 1'b1);
    @(posedge clk); #1;
    check("sel6_q", out_q, 1'b0);

    // Single-edge reset mid-operation, then reload on the next edge.
    @(negedge clk);
    in  = 16'h0001;
    sel = 4'd0;
    @(posedge clk); #1;
    check("mid_load_q", out_q, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_q", out_q, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_reload_q", out_q, 1'b1);

    // Random pairs, one per clock, with rst asserted about 5% of edges.
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      in_v  = 16'($urandom);
      sel_v = 4'($urandom_range(15));
      rst_v = ($urandom_range(99) < 5);
      in  = in_v;
      sel = sel_v;
      rst = rst_v;
      #1;
      exp_out = in_v[sel_v];
      check($sformatf("rand%0d_out", n), out, exp_out);
      exp_q = rst_v ? 1'b0 : exp_out;
      @(posedge clk); #1;
      check($sformatf("rand%0d_q", n), out_q, exp_q);
    end

    rst = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_16to1.md
# mux_16to1

Single-bit 16-to-1 selector. It routes one of sixteen input bits to a combinational output chosen by a 4-bit select. It also provides a registered copy of that output for downstream synchronous logic. The block is a leaf primitive used wherever one bit of a 16-bit vector must be picked by index (e.g. challenge/response bit selection).

## Interface
Parameters:
- None. Widths are fixed: 16 data inputs, 4-bit select, 1-bit output.

Ports:
- clk  input  1  system clock. One clock only; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in  input  16  data vector; bit i is candidate i.
- sel  input  4  unsigned index of the selected bit, 0..15.
- out  output  1  combinational selection, out = in[sel].
- out_q  output  1  registered copy of out.

## Operation
- Combinational path:
  - out = in[sel] for every sel value 0..15. There are no invalid codes.
  - Built as a balanced tree of 15 two-input muxes in 4 levels.
  - Level 0 pairs in[2k+1:2k] under sel[0]. Level 1 uses sel[1], level 2 uses sel[2], level 3 uses sel[3].
  - The tree result must equal in[sel] bit-exactly.
- out does not depend on clk or rst. It tracks in and sel at all times, including while rst is asserted.
- Registered path, on each rising clk edge:
  - If rst = 1: out_q <= 0.
  - Otherwise: out_q <= in[sel], using the values present at that edge.
- No enable, no handshake, no other state.
- Unknown inputs:
  - An X or Z on a selected in bit propagates to out.
  - An X on sel is not required to resolve. The result may be X unless all candidates agree.

## Timing
- out: zero-cycle, purely combinational latency from in/sel.
- out_q: one-cycle latency. It equals the out value sampled at the previous rising edge.
- Reset values:
  - out_q = 0 after any edge with rst = 1.
  - out has no reset value; it always equals in[sel].
- Reset mid-operation: asserting rst for one edge forces out_q to 0 on that edge. The first edge with rst = 0 reloads out_q from in[sel].
- Simultaneous changes of in and sel between edges: out settles to in_new[sel_new]. out_q captures only the settled value at the edge.
- sel wrap: incrementing sel from 15 wraps to 0 in the 4-bit domain. The block must select in[0] after the wrap.

## Test plan
- Counting data, fixed select: in = 0x0000, sel = 0, then increment in by 1 every 10 ns up to 0x0007. out must follow in[0]: 0,1,0,1,0,1,0,1.
- Select sweep with wrap: in = 0x0007, sel stepped 1,2,…,15,0 every 10 ns.
  - out = 1 for sel = 1, 2 and 0.
  - out = 0 for sel = 3..15.
- Walking one: for i = 0..15, set in = 1<<i and sweep sel 0..15. out = 1 only when sel == i.
- Walking zero: for i = 0..15, set in = ~(1<<i) and sweep sel 0..15. out = 0 only when sel == i.
- Register and reset:
  - Hold rst = 1 for 2 edges with in = 0xFFFF, sel = 5: out_q = 0 while out = 1.
  - Deassert rst: out_q = 1 after the next edge.
  - Change sel to 6 with in = 0xFFBF: out = 0 immediately; out_q = 0 one edge later.
- Random: 1000 random (in, sel) pairs, one per clock, with rst asserted randomly at about 5%. Check out == in[sel] each cycle. Check out_q == the previous cycle's in[sel], or 0 if rst was high at that edge.
